// File: rtl/mux4x1_arbiter.sv
// Round-robin arbiter driving the selects of a shared 4x1 mux, with a hold
// limit that forces rotation and a registered, flagged copy of the mux output.
module mux4x1_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] d,
    output logic [3:0] gnt,
    output logic       S1,
    output logic       S0,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_nx;
    logic [1:0] last, last_nx;
    logic [1:0] sel, sel_nx;
    logic [3:0] gnt_nx;
    logic [3:0] hold_cnt, hold_nx;
    logic [3:0] cand;
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    logic       at_limit;

    assign S1       = sel[1];
    assign S0       = sel[0];
    assign at_limit = (hold_cnt == 4'(MAX_HOLD));

    // In GRANT, last always equals the owner, so one search from last+1
    // serves both fresh arbitration and preemption (owner masked out).
    always_comb begin
        cand  = req;
        win   = '0;
        found = 1'b0;
        idx   = '0;
        if (state == GRANT) cand[sel] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        sel_nx   = sel;
        last_nx  = last;
        hold_nx  = hold_cnt;
        case (state)
            IDLE: begin
                if (found) begin
                    gnt_nx   = 4'b0001 << win;
                    sel_nx   = win;
                    last_nx  = win;
                    hold_nx  = 4'd1;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    gnt_nx   = '0;
                    hold_nx  = '0;
                    state_nx = IDLE;
                end else if (at_limit && found) begin
                    gnt_nx  = 4'b0001 << win;
                    sel_nx  = win;
                    last_nx = win;
                    hold_nx = 4'd1;
                end else if (!at_limit) begin
                    hold_nx = hold_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            sel      <= '0;
            last     <= 2'd3;
            hold_cnt <= '0;
            y        <= 1'b0;
            y_valid  <= 1'b0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            sel      <= sel_nx;
            last     <= last_nx;
            hold_cnt <= hold_nx;
            // data path samples the selects as they stood before this edge
            y        <= (gnt != '0) ? d[sel] : 1'b0;
            y_valid  <= (gnt != '0);
        end
    end

endmodule

// File: tb/tb_mux4x1_arbiter.sv
// Bench for mux4x1_arbiter: an ownership-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mux4x1_arbiter;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic       S1, S0, y, y_valid;

    int n_chk  = 0;
    int n_fail = 0;

    mux4x1_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .d(d),
        .gnt(gnt), .S1(S1), .S0(S0), .y(y), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    // model: who owns the channel (-1 = nobody), how long, and the select lines
    int   m_owner = -1;
    int   m_last  = 3;
    int   m_sel   = 0;
    int   m_held  = 0;
    logic m_y     = 1'b0;
    logic m_yv    = 1'b0;

    function automatic int pick(int from, logic [3:0] r, int excl);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner = -1; m_last = 3; m_sel = 0; m_held = 0; m_y = 1'b0; m_yv = 1'b0;
        end else begin
            logic ny, nyv;
            int   w;
            nyv = (m_owner >= 0);
            ny  = nyv ? d[m_sel] : 1'b0;
            if (m_owner < 0) begin
                w = pick(m_last, req, -1);
                if (w >= 0) begin
                    m_owner = w; m_sel = w; m_last = w; m_held = 1;
                end
            end else if (!req[m_owner]) begin
                m_owner = -1; m_held = 0;
            end else begin
                w = pick(m_owner, req, m_owner);
                if (m_held >= MAX_HOLD && w >= 0) begin
                    m_owner = w; m_sel = w; m_last = w; m_held = 1;
                end else begin
                    m_held++;
                end
            end
            m_y = ny; m_yv = nyv;
        end
    end

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model, away from the active edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("gnt", gnt, (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner));
            chk("sel", {2'b00, S1, S0}, 4'(m_sel));
            chk("y", {3'b000, y}, {3'b000, m_y});
            chk("y_valid", {3'b000, y_valid}, {3'b000, m_yv});
            chk("onehot", {3'b000, (gnt == 4'b0000) || (gnt == (4'b0001 << {S1, S0}))}, 4'b0001);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b1111; d = 4'b0000;
        tick(); tick();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_sel", {2'b00, S1, S0}, 4'b0000);
        chk("rst_y", {3'b000, y}, 4'b0000);
        chk("rst_yv", {3'b000, y_valid}, 4'b0000);

        // rotation with all four requesting
        rst_n = 1'b1; d = 4'b0110;
        tick(); chk("first_gnt", gnt, 4'b0001);
        tick(); chk("first_yv", {3'b000, y_valid}, 4'b0001);
        for (int n = 3; n <= 16; n++) begin
            tick(); chk("rotate", gnt, 4'b0001 << ((n - 1) / 4));
        end

        // lone requester 2 after owner 3 releases
        req = 4'b0100; d = 4'b0100;
        tick(); chk("rel_to_idle", gnt, 4'b0000);
        tick(); chk("single_gnt", gnt, 4'b0100);
        chk("single_sel", {2'b00, S1, S0}, 4'b0010);
        tick(); chk("single_y", {2'b00, y, y_valid}, 4'b0011);
        for (int n = 0; n < 20; n++) begin
            tick(); chk("single_hold", gnt, 4'b0100);
        end

        // reset in the middle of a grant
        rst_n = 1'b0;
        tick(); chk("mid_rst_gnt", gnt, 4'b0000);
        chk("mid_rst_sel", {2'b00, S1, S0}, 4'b0000);
        chk("mid_rst_yv", {3'b000, y_valid}, 4'b0000);
        rst_n = 1'b1; req = 4'b0110;
        tick(); chk("post_rst_gnt", gnt, 4'b0010);

        // owner 1 releases while 3 waits: exactly one idle cycle
        req = 4'b1010;
        tick();
        req = 4'b1000;
        tick(); chk("gap_gnt0", gnt, 4'b0000);
        chk("gap_yv_a", {3'b000, y_valid}, 4'b0001);
        tick(); chk("gap_gnt3", gnt, 4'b1000);
        chk("gap_yv_b", {3'b000, y_valid}, 4'b0000);
        tick(); chk("gap_yv_c", {3'b000, y_valid}, 4'b0001);

        // make last=2 then idle, then 3 must beat 0 and 1
        req = 4'b0100;
        tick(); tick(); chk("own2", gnt, 4'b0100);
        req = 4'b0000;
        tick(); chk("idle2", gnt, 4'b0000);
        req = 4'b1011;
        tick(); chk("fair_gnt", gnt, 4'b1000);

        // release at the hold limit wins over preemption
        tick(); tick(); tick(); chk("at_limit", gnt, 4'b1000);
        req = 4'b0011;
        tick(); chk("rel_pri", gnt, 4'b0000);
        tick(); chk("after_rel", gnt, 4'b0001);

        // random traffic, occasional resets, checked by the model only
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            req   = 4'($urandom_range(0, 15));
            d     = 4'($urandom_range(0, 15));
            tick();
        end
        rst_n = 1'b1; req = 4'b0000;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
